// File: rtl/sched_pkg.sv
// sched_pkg: constants and FSM state type shared by the batch scheduler,
// the batch buffers and the SPI serializer.
package sched_pkg;

    localparam int SCHED_ROWS      = 8;
    localparam int SCHED_ROW_W     = 64;
    localparam int SCHED_ROW_AW    = $clog2(SCHED_ROWS);
    localparam int SCHED_DRAIN_CYC = 16;
    localparam int SCHED_TIMEOUT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        HANDOFF
    } sched_state_e;

endpackage

// File: rtl/sched_row_fetch.sv
// sched_row_fetch: two-phase row reader. Phase 0 raises the shared read
// strobe with the row address; phase 1 is the buffer latency cycle, at the
// end of which both rows are captured and presented to the array for one
// cycle. The top FSM starts it, may abort it, and watches done.
module sched_row_fetch
    import sched_pkg::*;
#(
    parameter int ROWS   = SCHED_ROWS,
    parameter int ROW_W  = SCHED_ROW_W,
    parameter int ROW_AW = SCHED_ROW_AW
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start,
    input  logic              abort,
    output logic              done,
    output logic              rd_clk,
    output logic [ROW_AW-1:0] rd_row,
    input  logic [ROW_W-1:0]  data_row,
    input  logic [ROW_W-1:0]  weight_row,
    output logic [ROW_W-1:0]  arr_data,
    output logic [ROW_W-1:0]  arr_weight,
    output logic              arr_valid
);

    localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(ROWS - 1);

    logic              active;
    logic              phase;
    logic [ROW_AW-1:0] row;
    logic [ROW_W-1:0]  data_p1;
    logic [ROW_W-1:0]  weight_p1;
    logic              vld_p1;

    // Last row is being captured on this edge.
    assign done = active && phase && (row == LAST_ROW);

    assign arr_data   = data_p1;
    assign arr_weight = weight_p1;
    assign arr_valid  = vld_p1;

    // Strobe/phase sequencing and the single capture stage towards the array
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            active    <= 1'b0;
            phase     <= 1'b0;
            row       <= '0;
            rd_clk    <= 1'b0;
            rd_row    <= '0;
            data_p1   <= '0;
            weight_p1 <= '0;
            vld_p1    <= 1'b0;
        end else begin
            // Array inputs carry a row for exactly one cycle, zero otherwise.
            vld_p1    <= 1'b0;
            data_p1   <= '0;
            weight_p1 <= '0;
            if (abort) begin
                active <= 1'b0;
                phase  <= 1'b0;
                row    <= '0;
                rd_clk <= 1'b0;
                rd_row <= '0;
            end else if (start) begin
                active <= 1'b1;
                phase  <= 1'b0;
                row    <= '0;
                rd_clk <= 1'b1;
                rd_row <= '0;
            end else if (active) begin
                if (!phase) begin
                    rd_clk <= 1'b0;
                    phase  <= 1'b1;
                end else begin
                    // ---- capture stage: buffer rows valid now ----
                    data_p1   <= data_row;
                    weight_p1 <= weight_row;
                    vld_p1    <= 1'b1;
                    phase     <= 1'b0;
                    row       <= row + ROW_AW'(1);
                    if (row == LAST_ROW) begin
                        active <= 1'b0;
                        rd_clk <= 1'b0;
                        rd_row <= '0;
                    end else begin
                        rd_clk <= 1'b1;
                        rd_row <= row + ROW_AW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/systolic_batch_sched.sv
// systolic_batch_sched: runs one matrix batch through the systolic array:
// wait for both buffers, fetch all rows in lockstep, let the array drain,
// then hold results for the SPI serializer until it clears the array.
// Optional feature macro: SCHED_PERF_EN adds o_perf_cyc, the cycle count
// from FETCH entry to o_done of the last successful batch.
module systolic_batch_sched
    import sched_pkg::*;
#(
    parameter int ROWS      = SCHED_ROWS,
    parameter int ROW_W     = SCHED_ROW_W,
    parameter int ROW_AW    = SCHED_ROW_AW,
    parameter int DRAIN_CYC = SCHED_DRAIN_CYC,
    parameter int TIMEOUT_W = SCHED_TIMEOUT_W
) (
    input  logic              i_clk,
    input  logic              i_clr_n,
    input  logic              i_data_rdy,
    input  logic              i_weight_rdy,
    output logic              o_rd_clk,
    output logic [ROW_AW-1:0] o_rd_row,
    input  logic [ROW_W-1:0]  i_data_row,
    input  logic [ROW_W-1:0]  i_weight_row,
    output logic [ROW_W-1:0]  o_arr_data,
    output logic [ROW_W-1:0]  o_arr_weight,
    output logic              o_arr_valid,
    output logic              o_res_valid,
    input  logic              i_ser_clr,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
`ifdef SCHED_PERF_EN
    ,
    output logic [15:0]       o_perf_cyc
`endif
);

    localparam int DCNT_W = $clog2(DRAIN_CYC) + 1;
    localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_CYC - 1);
    // The timeout counter saturates at all-ones; leaving from the cycle whose
    // increment would reach it keeps o_res_valid up for 2^TIMEOUT_W-1 cycles.
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    sched_state_e         state;
    logic [DCNT_W-1:0]    dcnt;
    logic [TIMEOUT_W-1:0] tmo;
    logic                 both_rdy;
    logic                 start;
    logic                 abort;
    logic                 fetch_done;

    assign both_rdy = i_data_rdy && i_weight_rdy;
    assign start    = (state == IDLE) && both_rdy;
    assign abort    = (state == FETCH) && !both_rdy;

    sched_row_fetch #(
        .ROWS   (ROWS),
        .ROW_W  (ROW_W),
        .ROW_AW (ROW_AW)
    ) u_fetch (
        .clk        (i_clk),
        .clr_n      (i_clr_n),
        .start      (start),
        .abort      (abort),
        .done       (fetch_done),
        .rd_clk     (o_rd_clk),
        .rd_row     (o_rd_row),
        .data_row   (i_data_row),
        .weight_row (i_weight_row),
        .arr_data   (o_arr_data),
        .arr_weight (o_arr_weight),
        .arr_valid  (o_arr_valid)
    );

    // Batch FSM: sequencing, drain timing, serializer handoff and status flags
    always_ff @(posedge i_clk) begin
        if (!i_clr_n) begin
            state       <= IDLE;
            dcnt        <= '0;
            tmo         <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
            o_res_valid <= 1'b0;
        end else begin
            o_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (both_rdy) begin
                        o_err  <= 1'b0;
                        o_busy <= 1'b1;
                        state  <= FETCH;
                    end
                end
                FETCH: begin
                    if (!both_rdy) begin
                        o_err  <= 1'b1;
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end else if (fetch_done) begin
                        // The last row is still on the array bus during the
                        // first DRAIN cycle; the drain count includes it.
                        dcnt  <= '0;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (dcnt == DRAIN_LAST) begin
                        tmo         <= '0;
                        o_res_valid <= 1'b1;
                        state       <= HANDOFF;
                    end else begin
                        dcnt <= dcnt + DCNT_W'(1);
                    end
                end
                HANDOFF: begin
                    if (i_ser_clr) begin
                        o_done      <= 1'b1;
                        o_res_valid <= 1'b0;
                        o_busy      <= 1'b0;
                        state       <= IDLE;
                    end else if (tmo == TMO_LAST) begin
                        o_err       <= 1'b1;
                        o_res_valid <= 1'b0;
                        o_busy      <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        tmo <= tmo + TIMEOUT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SCHED_PERF_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] cyc_cnt;

    // Cycle count since FETCH entry, latched into o_perf_cyc on a successful handoff
    always_ff @(posedge i_clk) begin
        if (!i_clr_n) begin
            cyc_cnt    <= '0;
            o_perf_cyc <= '0;
        end else begin
            if (start) begin
                cyc_cnt <= '0;
            end else if (state != IDLE) begin
                cyc_cnt <= sat_inc16(cyc_cnt);
            end
            if ((state == HANDOFF) && i_ser_clr) begin
                o_perf_cyc <= sat_inc16(cyc_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_systolic_batch_sched.sv
// tb_systolic_batch_sched: directed scoreboard bench for systolic_batch_sched.
// The bench acts as both batch buffers (row data = batch tag/row index,
// weight = its inverse) and as the serializer acknowledging the handoff.
module tb_systolic_batch_sched;

    localparam int ROWS   = 8;
    localparam int ROW_W  = 64;
    localparam int ROW_AW = 3;
    localparam int TMO_W  = 4;

    typedef struct {
        logic [ROW_W-1:0] d;
        logic [ROW_W-1:0] w;
    } exp_t;

    logic              clk;
    logic              clr_n;
    logic              data_rdy;
    logic              weight_rdy;
    logic              rd_clk;
    logic [ROW_AW-1:0] rd_row;
    logic [ROW_W-1:0]  data_row;
    logic [ROW_W-1:0]  weight_row;
    logic [ROW_W-1:0]  arr_data;
    logic [ROW_W-1:0]  arr_weight;
    logic              arr_valid;
    logic              res_valid;
    logic              ser_clr;
    logic              busy;
    logic              done;
    logic              err;
`ifdef SCHED_PERF_EN
    logic [15:0]       perf_cyc;
`endif

    systolic_batch_sched #(
        .ROWS      (ROWS),
        .ROW_W     (ROW_W),
        .ROW_AW    (ROW_AW),
        .DRAIN_CYC (16),
        .TIMEOUT_W (TMO_W)
    ) dut (
        .i_clk        (clk),
        .i_clr_n      (clr_n),
        .i_data_rdy   (data_rdy),
        .i_weight_rdy (weight_rdy),
        .o_rd_clk     (rd_clk),
        .o_rd_row     (rd_row),
        .i_data_row   (data_row),
        .i_weight_row (weight_row),
        .o_arr_data   (arr_data),
        .o_arr_weight (arr_weight),
        .o_arr_valid  (arr_valid),
        .o_res_valid  (res_valid),
        .i_ser_clr    (ser_clr),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err)
`ifdef SCHED_PERF_EN
        ,
        .o_perf_cyc   (perf_cyc)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t q[$];

    logic              prev_rd_clk = 1'b0;
    logic [ROW_AW-1:0] prev_rd_row = '0;
    logic              prev_busy   = 1'b0;
    logic              prev_resv   = 1'b0;
    int   n_strobe, n_valid, n_done, n_resv;
    int   last_valid_cyc, res_rise_cyc, done_cyc, busy_rise_cyc, last_strobe_cyc;
    int   batch_strobes = 0;
    int   exp_row       = 0;
    int   batch_id      = 0;
    logic err_at_start  = 1'b0;
    logic saw_busy;
    int   snap;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_stats();
        n_strobe = 0;
        n_valid  = 0;
        n_done   = 0;
        n_resv   = 0;
    endtask

    // One clock: buffer model answers last cycle's strobe, scoreboard pops on valid.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (prev_rd_clk) begin
            e.d = 64'(batch_id * 256 + int'(prev_rd_row));
            e.w = ~e.d;
            data_row   = e.d;
            weight_row = e.w;
            q.push_back(e);
        end
        if (busy && !prev_busy) begin
            busy_rise_cyc = cyc;
            batch_id++;
            exp_row       = 0;
            batch_strobes = 0;
            err_at_start  = err;
        end
        if (rd_clk && !prev_rd_clk) begin
            check("rd_row", 64'(rd_row), 64'(exp_row));
            if (batch_strobes > 0) check("strobe_gap", 64'(cyc - last_strobe_cyc), 64'(2));
            exp_row = (exp_row + 1) % ROWS;
            batch_strobes++;
            n_strobe++;
            last_strobe_cyc = cyc;
        end
        if (arr_valid) begin
            n_valid++;
            last_valid_cyc = cyc;
            check("arr_q_nonempty", 64'(q.size() != 0), 64'(1));
            if (q.size() != 0) begin
                e = q.pop_front();
                check("arr_data", arr_data, e.d);
                check("arr_weight", arr_weight, e.w);
            end
        end
        if (res_valid) n_resv++;
        if (res_valid && !prev_resv) res_rise_cyc = cyc;
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
        prev_rd_clk = rd_clk;
        prev_rd_row = rd_row;
        prev_busy   = busy;
        prev_resv   = res_valid;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_rd_clk"}, 64'(rd_clk), 64'(0));
        check({tag, "_rd_row"}, 64'(rd_row), 64'(0));
        check({tag, "_arr_valid"}, 64'(arr_valid), 64'(0));
        check({tag, "_arr_data"}, arr_data, 64'(0));
        check({tag, "_arr_weight"}, arr_weight, 64'(0));
        check({tag, "_res_valid"}, 64'(res_valid), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_err"}, 64'(err), 64'(0));
`ifdef SCHED_PERF_EN
        check({tag, "_perf"}, 64'(perf_cyc), 64'(0));
`endif
    endtask

    initial begin
        clr_n      = 1'b0;
        data_rdy   = 1'b0;
        weight_rdy = 1'b0;
        ser_clr    = 1'b0;
        data_row   = '0;
        weight_row = '0;
        clr_stats();

        // ---- reset state ----
        repeat (3) tick();
        check_all_zero("reset");
        clr_n = 1'b1;
        tick();

        // ---- nominal batch, ack 5 cycles after results valid ----
        clr_stats();
        data_rdy   = 1'b1;
        weight_rdy = 1'b1;
        for (int k = 0; k < 100 && !res_valid; k++) tick();
        check("nom_wait_resv", 64'(res_valid), 64'(1));
        check("nom_err_start", 64'(err_at_start), 64'(0));
        check("nom_strobes", 64'(n_strobe), 64'(8));
        check("nom_valids", 64'(n_valid), 64'(8));
        check("nom_fetch_len", 64'(last_valid_cyc - busy_rise_cyc), 64'(16));
        check("nom_drain_len", 64'(res_rise_cyc - last_valid_cyc), 64'(16));
        repeat (5) tick();
        check("nom_resv_held", 64'(res_valid), 64'(1));
        check("nom_no_early_done", 64'(n_done), 64'(0));
        ser_clr    = 1'b1;
        data_rdy   = 1'b0;
        weight_rdy = 1'b0;
        tick();
        ser_clr = 1'b0;
        check("nom_done", 64'(done), 64'(1));
        check("nom_resv_drop", 64'(res_valid), 64'(0));
        check("nom_busy_drop", 64'(busy), 64'(0));
        check("nom_ack_lat", 64'(done_cyc - res_rise_cyc), 64'(6));
`ifdef SCHED_PERF_EN
        check("nom_perf", 64'(perf_cyc), 64'(38));
`endif
        tick();
        check("nom_done_pulse", 64'(done), 64'(0));
        check("nom_done_count", 64'(n_done), 64'(1));
        check("nom_err", 64'(err), 64'(0));
        check("nom_q_empty", 64'(q.size()), 64'(0));

        // ---- single ready: nothing must start ----
        clr_stats();
        saw_busy = 1'b0;
        data_rdy = 1'b1;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (busy) saw_busy = 1'b1;
        end
        check("single_busy", 64'(saw_busy), 64'(0));
        check("single_strobes", 64'(n_strobe), 64'(0));
        data_rdy = 1'b0;
        tick();

        // ---- ready drop after the third array valid ----
        clr_stats();
        data_rdy   = 1'b1;
        weight_rdy = 1'b1;
        for (int k = 0; k < 60 && n_valid < 3; k++) tick();
        check("drop_wait_v3", 64'(n_valid), 64'(3));
        weight_rdy = 1'b0;
        tick();
        check("drop_busy", 64'(busy), 64'(0));
        check("drop_err", 64'(err), 64'(1));
        check("drop_rd_clk", 64'(rd_clk), 64'(0));
        check("drop_arr_valid", 64'(arr_valid), 64'(0));
        snap = n_strobe;
        q.delete();
        repeat (30) tick();
        check("drop_no_strobe", 64'(n_strobe), 64'(snap));
        check("drop_valids", 64'(n_valid), 64'(3));
        check("drop_no_resv", 64'(n_resv), 64'(0));
        check("drop_no_done", 64'(n_done), 64'(0));
        check("drop_err_sticky", 64'(err), 64'(1));
        data_rdy = 1'b0;
        tick();

        // ---- serializer timeout ----
        clr_stats();
        q.delete();
        data_rdy   = 1'b1;
        weight_rdy = 1'b1;
        for (int k = 0; k < 100 && !res_valid; k++) tick();
        check("tmo_wait_resv", 64'(res_valid), 64'(1));
        check("tmo_err_cleared", 64'(err_at_start), 64'(0));
        data_rdy   = 1'b0;
        weight_rdy = 1'b0;
        for (int k = 0; k < 40 && res_valid; k++) tick();
        check("tmo_resv_drop", 64'(res_valid), 64'(0));
        check("tmo_resv_cycles", 64'(n_resv), 64'(15));
        check("tmo_err", 64'(err), 64'(1));
        check("tmo_no_done", 64'(n_done), 64'(0));
        check("tmo_busy", 64'(busy), 64'(0));
`ifdef SCHED_PERF_EN
        check("tmo_perf_kept", 64'(perf_cyc), 64'(38));
`endif

        // ---- reset while draining ----
        clr_stats();
        data_rdy   = 1'b1;
        weight_rdy = 1'b1;
        for (int k = 0; k < 60 && n_valid < 8; k++) tick();
        check("rst_wait_v8", 64'(n_valid), 64'(8));
        repeat (3) tick();
        check("rst_in_drain_busy", 64'(busy), 64'(1));
        clr_n      = 1'b0;
        data_rdy   = 1'b0;
        weight_rdy = 1'b0;
        tick();
        check_all_zero("rst_drain");
        clr_n = 1'b1;
        tick();

        // ---- restart from row 0, then back-to-back with immediate ack ----
        clr_stats();
        data_rdy   = 1'b1;
        weight_rdy = 1'b1;
        for (int k = 0; k < 100 && !res_valid; k++) tick();
        check("b2b_wait_resv1", 64'(res_valid), 64'(1));
        check("b2b_valids1", 64'(n_valid), 64'(8));
        ser_clr = 1'b1;
        tick();
        ser_clr = 1'b0;
        check("b2b_done1", 64'(done), 64'(1));
        check("b2b_ack_lat1", 64'(done_cyc - res_rise_cyc), 64'(1));
        check("b2b_idle_cycle", 64'(busy), 64'(0));
`ifdef SCHED_PERF_EN
        check("b2b_perf1", 64'(perf_cyc), 64'(33));
`endif
        tick();
        check("b2b_restart_busy", 64'(busy), 64'(1));
        check("b2b_restart_cyc", 64'(busy_rise_cyc), 64'(done_cyc + 1));
        for (int k = 0; k < 100 && !res_valid; k++) tick();
        check("b2b_wait_resv2", 64'(res_valid), 64'(1));
        ser_clr    = 1'b1;
        data_rdy   = 1'b0;
        weight_rdy = 1'b0;
        tick();
        ser_clr = 1'b0;
        check("b2b_done2", 64'(done), 64'(1));
`ifdef SCHED_PERF_EN
        check("b2b_perf2", 64'(perf_cyc), 64'(33));
`endif
        tick();
        check("b2b_done_pulse", 64'(done), 64'(0));
        check("b2b_busy_end", 64'(busy), 64'(0));
        check("b2b_valids", 64'(n_valid), 64'(16));
        check("b2b_strobes", 64'(n_strobe), 64'(16));
        check("b2b_done_count", 64'(n_done), 64'(2));
        check("b2b_err", 64'(err), 64'(0));
        check("b2b_q_empty", 64'(q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/systolic_batch_sched.md
Name: systolic_batch_sched

Overview:
Sequences one matrix batch through the systolic MAC array. Waits until both the data batch buffer and the weight batch buffer report a complete batch. Reads the rows of both buffers in lockstep and feeds them to the array, then waits for the array pipeline to drain. Hands the accumulated results to the SPI serializer and re-arms once the serializer has cleared the array.

Parameters:
ROWS, 8, rows per batch; power of two
ROW_W, 64, bits per buffer row (8 lanes x 8 bits)
ROW_AW, $clog2(ROWS), row address width (3 at default)
DRAIN_CYC, 16, cycles to wait after the last row for partial sums to settle
TIMEOUT_W, 16, width of the serializer-handoff timeout counter

Ports:
i_clk  in  1  system clock, single clock domain
i_clr_n  in  1  synchronous active-low reset
i_data_rdy  in  1  data buffer has a full batch (o_rd_ready of data buffer)
i_weight_rdy  in  1  weight buffer has a full batch
o_rd_clk  out  1  read strobe, drives i_rd_clk of both buffers
o_rd_row  out  ROW_AW  row address, shared by both buffers
i_data_row  in  ROW_W  data buffer o_data
i_weight_row  in  ROW_W  weight buffer o_data
o_arr_data  out  ROW_W  data row to array
o_arr_weight  out  ROW_W  weight row to array
o_arr_valid  out  1  array shifts/accumulates this cycle
o_res_valid  out  1  results stable; serializer may read
i_ser_clr  in  1  serializer clear pulse (o_clr of serializer), ends handoff
o_busy  out  1  high in every state except IDLE
o_done  out  1  one-cycle pulse when a batch completes
o_err  out  1  sticky abort/timeout flag; cleared on next batch start

Behaviour:
- Reset (i_clr_n=0 at a clk edge) takes priority over everything. It forces IDLE and drives every output to 0, o_rd_row=0 and all counters=0. This applies mid-operation too; no partial handoff is preserved.
- FSM: IDLE -> FETCH -> DRAIN -> HANDOFF -> IDLE; any abort goes to IDLE.
- IDLE: when i_data_rdy & i_weight_rdy are both sampled high, clear o_err, set row=0 and go to FETCH.
- FETCH handles one row per 2 cycles (phase bit).
  - Phase 0: o_rd_clk=1, o_rd_row=row.
  - Phase 1: o_rd_clk=0. Buffer data is valid in this cycle (1-cycle buffer latency from the strobe edge).
  - At the end of phase 1 the scheduler registers i_data_row and i_weight_row into o_arr_data and o_arr_weight, and sets o_arr_valid=1 for exactly the next cycle.
  - After row ROWS-1 is registered, go to DRAIN.
  - FETCH lasts 2*ROWS cycles; the last o_arr_valid occurs at FETCH entry + 2*ROWS.
- The row counter wraps at ROWS-1 -> 0 and is never reused within a batch.
- If either ready input drops during FETCH: abort to IDLE, set o_err=1, o_arr_valid=0, o_rd_clk=0.
- DRAIN: o_arr_valid=0 and o_arr_data/o_arr_weight held at 0. Count DRAIN_CYC cycles, then go to HANDOFF.
- HANDOFF:
  - o_res_valid=1 and the timeout counter runs.
  - On i_ser_clr=1: o_done pulses 1 cycle, o_res_valid=0, go to IDLE.
  - If the timeout counter saturates (2^TIMEOUT_W-1): set o_err=1 and go to IDLE without o_done.
- i_ser_clr outside HANDOFF is ignored.
- Ready inputs high in the cycle that returns to IDLE: the next batch starts on the following edge (1 idle cycle minimum).
- o_busy=1 in FETCH/DRAIN/HANDOFF. The scheduler generates no array clear of its own; the serializer owns array clear.

Optional Feature:
SCHED_PERF_EN
- Defined: adds output o_perf_cyc [15:0], a saturating count of cycles from FETCH entry to o_done of the last successful batch. It is updated in the o_done cycle and reset to 0 by i_clr_n. Aborted batches do not update it.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Package sched_pkg holds:
  - state enum (IDLE, FETCH, DRAIN, HANDOFF)
  - ROWS, ROW_W and ROW_AW defaults
  - DRAIN_CYC default
- The buffer and serializer blocks share the same constants.
- One sub-module, sched_row_fetch: the 2-phase strobe/row counter/register stage. It has start, abort and done handshakes with the top FSM.

Test Plan:
- Nominal batch: set both ready inputs =1, load rows with data=row index and weight=~index, pulse i_ser_clr 5 cycles after o_res_valid. Required: o_rd_row goes 0..7 on o_rd_clk rising every 2 cycles, 8 o_arr_valid pulses carry the matching rows, o_res_valid rises 16 cycles after the last valid, o_done pulses once, o_err=0.
- Single ready: only i_data_rdy=1 for 50 cycles. Required: o_busy=0, o_rd_clk never toggles.
- Ready drop mid-fetch: drop i_weight_rdy after the 3rd o_arr_valid. Required: IDLE next cycle, o_err=1, no further strobes, no o_res_valid, no o_done.
- Serializer timeout: hold i_ser_clr=0 in HANDOFF, TIMEOUT_W=4. Required: o_res_valid drops after 15 cycles, o_err=1, no o_done; the next start clears o_err.
- Reset in DRAIN: assert i_clr_n=0 for 1 cycle. Required: all outputs 0 on the next edge; a restart then reads from row 0.
- Back-to-back with SCHED_PERF_EN: keep ready high and ack immediately. Required: second FETCH begins 1 idle cycle after o_done, and o_perf_cyc = 2*8+16+ack latency (e.g. 33 for a 1-cycle ack).
